// File: rtl/centroid_pkg.sv
// Shared types and elaboration-time helpers for the multi-band line-centroid engine.
package centroid_pkg;

  typedef enum logic [1:0] {ACCUM, DIVIDE, PUBLISH} fsm_t;

  function automatic int xw(input int img_w);
    return $clog2(img_w) + 1;
  endfunction

  function automatic int sw(input int pix_w, input int img_w, input int roi_h);
    return pix_w + $clog2(img_w * roi_h + 1);
  endfunction

  // Band 0 sits at the bottom of the frame; higher bands stack upwards.
  function automatic int band_lo(input int img_h, input int roi_h, input int k);
    return img_h - (k + 1) * roi_h;
  endfunction

  function automatic int band_hi(input int img_h, input int roi_h, input int k);
    return img_h - k * roi_h - 1;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per cycle, then a one-cycle done pulse.
module seq_divider #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8,
  parameter int QUOT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  done
);

  localparam int RW = (DIVIDEND_W > DIVISOR_W + QUOT_W) ? DIVIDEND_W : DIVISOR_W + QUOT_W;
  localparam int CW = $clog2(QUOT_W + 1);

  logic [RW-1:0] rem;
  logic [RW-1:0] dsh;
  logic [CW-1:0] cnt;
  logic          take;

  assign take = (rem >= dsh);

  // The divisor starts aligned to the quotient MSB and walks right one bit per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      dsh      <= '0;
      cnt      <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= RW'(dividend);
        dsh      <= RW'(divisor) << (QUOT_W - 1);
        cnt      <= CW'(QUOT_W);
        quotient <= '0;
      end else if (cnt != '0) begin
        if (take) rem <= rem - dsh;
        dsh      <= dsh >> 1;
        quotient <= {quotient[QUOT_W-2:0], take};
        cnt      <= cnt - 1'b1;
        done     <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/multi_roi_centroid.sv
// Per-band intensity-weighted centroid over NUM_ROI bottom bands, published once per frame.
// Define MULTI_ROI_CENTROID_HEADING_EN to add the signed heading / heading_valid outputs.
module multi_roi_centroid
  import centroid_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int PIX_W      = 4,
  parameter int NUM_ROI    = 4,
  parameter int ROI_HEIGHT = 60,
  parameter int THRESHOLD  = 0,
  parameter int MIN_WEIGHT = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [PIX_W-1:0]                pixel_in,
  input  logic                            in_ready,
  output logic [NUM_ROI*xw(IMG_W)-1:0]    centroid_x,
  output logic [NUM_ROI-1:0]              roi_valid,
  output logic                            line_valid,
  output logic                            line_lost
`ifdef MULTI_ROI_CENTROID_HEADING_EN
  ,
  output logic signed [xw(IMG_W):0]       heading,
  output logic                            heading_valid
`endif
);

  localparam int XW  = xw(IMG_W);
  localparam int SW  = sw(PIX_W, IMG_W, ROI_HEIGHT);
  localparam int SWX = SW + XW;
  localparam int XCW = $clog2(IMG_W);
  localparam int YCW = $clog2(IMG_H);
  localparam int BW  = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;

  logic [XCW-1:0]         x;
  logic [YCW-1:0]         y;
  logic                   in_band;
  logic                   last_row;
  logic [BW-1:0]          band_idx;
  logic                   hit;
  logic                   band_done;
  logic                   div_start;
  logic [SW-1:0]          sum_w;
  logic [SWX-1:0]         sum_wx;
  logic [SW-1:0]          w_nxt;
  logic [SWX-1:0]         wx_nxt;
  logic [BW-1:0]          cur_band;
  logic                   skip_r;
  logic [XW-1:0]          quotient;
  logic                   div_done;
  logic                   res_ready;
  logic                   shadow_we;
  logic                   publish;
  logic [NUM_ROI*XW-1:0]  shadow_x;
  logic [NUM_ROI-1:0]     shadow_valid;
  fsm_t                   state;
  fsm_t                   state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (in_ready) begin
      if (x == XCW'(IMG_W - 1)) begin
        x <= '0;
        y <= (y == YCW'(IMG_H - 1)) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_comb begin
    in_band  = 1'b0;
    last_row = 1'b0;
    band_idx = '0;
    for (int k = 0; k < NUM_ROI; k++) begin
      if (int'(y) >= band_lo(IMG_H, ROI_HEIGHT, k) && int'(y) <= band_hi(IMG_H, ROI_HEIGHT, k)) begin
        in_band  = 1'b1;
        last_row = (int'(y) == band_hi(IMG_H, ROI_HEIGHT, k));
        band_idx = BW'(k);
      end
    end
  end

  // The completing pixel is folded into the sums handed to the divider.
  assign hit       = in_ready && in_band && (pixel_in > PIX_W'(THRESHOLD));
  assign w_nxt     = sum_w + (hit ? SW'(pixel_in) : SW'(0));
  assign wx_nxt    = sum_wx + (hit ? SWX'(x) * SWX'(pixel_in) : SWX'(0));
  assign band_done = in_ready && in_band && last_row && (x == XCW'(IMG_W - 1));
  assign div_start = band_done && (w_nxt >= SW'(MIN_WEIGHT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_w    <= '0;
      sum_wx   <= '0;
      cur_band <= '0;
      skip_r   <= 1'b0;
    end else if (band_done) begin
      sum_w    <= '0;
      sum_wx   <= '0;
      cur_band <= band_idx;
      skip_r   <= !div_start;
    end else if (hit) begin
      sum_w  <= w_nxt;
      sum_wx <= wx_nxt;
    end
  end

  seq_divider #(
    .DIVIDEND_W (SWX),
    .DIVISOR_W  (SW),
    .QUOT_W     (XW)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (wx_nxt),
    .divisor  (w_nxt),
    .quotient (quotient),
    .done     (div_done)
  );

  assign res_ready = skip_r || div_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (band_done) state_nxt = DIVIDE;
      DIVIDE:  if (res_ready) state_nxt = (cur_band == '0) ? PUBLISH : ACCUM;
      PUBLISH: state_nxt = band_done ? DIVIDE : ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    shadow_we = (state == DIVIDE) && res_ready;
    publish   = (state == PUBLISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_x     <= '0;
      shadow_valid <= '0;
    end else if (shadow_we) begin
      shadow_x[int'(cur_band)*XW +: XW] <= skip_r ? '0 : quotient;
      shadow_valid[cur_band]            <= !skip_r;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      centroid_x <= '0;
      roi_valid  <= '0;
      line_valid <= 1'b0;
      line_lost  <= 1'b0;
    end else begin
      line_valid <= publish;
      if (publish) begin
        centroid_x <= shadow_x;
        roi_valid  <= shadow_valid;
        line_lost  <= ~|shadow_valid;
      end
    end
  end

`ifdef MULTI_ROI_CENTROID_HEADING_EN
  logic signed [XW:0] heading_nxt;

  always_comb begin
    heading_nxt = '0;
    if (shadow_valid[0] && shadow_valid[NUM_ROI-1])
      heading_nxt = $signed({1'b0, shadow_x[(NUM_ROI-1)*XW +: XW]}) - $signed({1'b0, shadow_x[XW-1:0]});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      heading       <= '0;
      heading_valid <= 1'b0;
    end else if (publish) begin
      heading       <= heading_nxt;
      heading_valid <= shadow_valid[0] && shadow_valid[NUM_ROI-1];
    end
  end
`endif

endmodule

// File: tb/tb_multi_roi_centroid.sv
// Frame-level scoreboard bench for multi_roi_centroid on a small 16x8 image with two bands.
module tb_multi_roi_centroid;

  localparam int IMG_W      = 16;
  localparam int IMG_H      = 8;
  localparam int PIX_W      = 4;
  localparam int NUM_ROI    = 2;
  localparam int ROI_HEIGHT = 2;
  localparam int THRESHOLD  = 0;
  localparam int MIN_WEIGHT = 4;
  localparam int XW         = $clog2(IMG_W) + 1;
  localparam int NPIX       = IMG_W * IMG_H;

  typedef struct {
    int cx0;
    int cx1;
    int vld;
    int lost;
    int edge_n;
    int hd;
    int hv;
  } res_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [PIX_W-1:0]       pixel_in;
  logic                   in_ready;
  logic [NUM_ROI*XW-1:0]  centroid_x;
  logic [NUM_ROI-1:0]     roi_valid;
  logic                   line_valid;
  logic                   line_lost;
`ifdef MULTI_ROI_CENTROID_HEADING_EN
  logic signed [XW:0]     heading;
  logic                   heading_valid;
`endif

  int   frame [IMG_H][IMG_W];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  res_t exp_q[$];
  res_t obs_q[$];

  multi_roi_centroid #(
    .IMG_W      (IMG_W),
    .IMG_H      (IMG_H),
    .PIX_W      (PIX_W),
    .NUM_ROI    (NUM_ROI),
    .ROI_HEIGHT (ROI_HEIGHT),
    .THRESHOLD  (THRESHOLD),
    .MIN_WEIGHT (MIN_WEIGHT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_in   (pixel_in),
    .in_ready   (in_ready),
    .centroid_x (centroid_x),
    .roi_valid  (roi_valid),
    .line_valid (line_valid),
    .line_lost  (line_lost)
`ifdef MULTI_ROI_CENTROID_HEADING_EN
    ,
    .heading       (heading),
    .heading_valid (heading_valid)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with line_valid high is captured, so a stretched pulse shows up as an extra result.
  always @(negedge clk) begin
    res_t r;
    if (line_valid) begin
      r.cx0    = int'(centroid_x[XW-1:0]);
      r.cx1    = int'(centroid_x[2*XW-1:XW]);
      r.vld    = int'(roi_valid);
      r.lost   = int'(line_lost);
      r.edge_n = cyc;
`ifdef MULTI_ROI_CENTROID_HEADING_EN
      r.hd     = int'(heading);
      r.hv     = int'(heading_valid);
`else
      r.hd     = 0;
      r.hv     = 0;
`endif
      obs_q.push_back(r);
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: straight sums over each band's rows, then integer division.
  function automatic res_t model();
    res_t r;
    int   cx [NUM_ROI];
    int   vmask;
    vmask = 0;
    for (int k = 0; k < NUM_ROI; k++) begin
      int w, wx;
      w  = 0;
      wx = 0;
      for (int yy = IMG_H - (k + 1) * ROI_HEIGHT; yy < IMG_H - k * ROI_HEIGHT; yy++)
        for (int xx = 0; xx < IMG_W; xx++)
          if (frame[yy][xx] > THRESHOLD) begin
            w  += frame[yy][xx];
            wx += xx * frame[yy][xx];
          end
      cx[k] = (w >= MIN_WEIGHT) ? wx / w : 0;
      if (w >= MIN_WEIGHT) vmask |= (1 << k);
    end
    r.cx0    = cx[0];
    r.cx1    = cx[1];
    r.vld    = vmask;
    r.lost   = (vmask == 0) ? 1 : 0;
    r.hv     = (vmask == 3) ? 1 : 0;
    r.hd     = (vmask == 3) ? cx[1] - cx[0] : 0;
    r.edge_n = 0;
    return r;
  endfunction

  task automatic clearFrame();
    for (int yy = 0; yy < IMG_H; yy++)
      for (int xx = 0; xx < IMG_W; xx++)
        frame[yy][xx] = 0;
  endtask

  task automatic randomFrame(input int density);
    for (int yy = 0; yy < IMG_H; yy++)
      for (int xx = 0; xx < IMG_W; xx++)
        frame[yy][xx] = ($urandom_range(99) < density) ? int'($urandom_range(15)) : 0;
  endtask

  // Streams the first npix raster pixels; in_ready stays high afterwards so frames can run back to back.
  task automatic applyStimulus(input int gap_pct, input int npix, input bit record);
    res_t e;
    e = model();
    for (int i = 0; i < npix; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        @(negedge clk);
        in_ready = 1'b0;
      end
      @(negedge clk);
      pixel_in = PIX_W'(frame[i / IMG_W][i % IMG_W]);
      in_ready = 1'b1;
      if (i == NPIX - 1)
        e.edge_n = cyc + 1 + (((e.vld & 1) != 0) ? XW + 2 : 2);
    end
    if (record && npix == NPIX) exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_ready = 1'b0;
    end
  endtask

  task automatic drainAndCheck(input string tag);
    res_t e, o;
    idle(1);
    for (int i = 0; i < 60 && obs_q.size() < exp_q.size(); i++) idle(1);
    idle(10);
    checkOutput({tag, "_pulse_count"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checkOutput({tag, "_cx0"}, o.cx0, e.cx0);
      checkOutput({tag, "_cx1"}, o.cx1, e.cx1);
      checkOutput({tag, "_roi_valid"}, o.vld, e.vld);
      checkOutput({tag, "_line_lost"}, o.lost, e.lost);
      checkOutput({tag, "_latency_edge"}, o.edge_n, e.edge_n);
`ifdef MULTI_ROI_CENTROID_HEADING_EN
      checkOutput({tag, "_heading"}, o.hd, e.hd);
      checkOutput({tag, "_heading_valid"}, o.hv, e.hv);
`endif
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "_centroid_x"}, int'(centroid_x), 0);
    checkOutput({tag, "_roi_valid"}, int'(roi_valid), 0);
    checkOutput({tag, "_line_valid"}, int'(line_valid), 0);
    checkOutput({tag, "_line_lost"}, int'(line_lost), 0);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    in_ready = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkCleared("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic frameA();
    clearFrame();
    frame[7][5] = 15;
    frame[5][9] = 15;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_ready = 1'b0;
    pixel_in = '0;
    #1;
    checkCleared("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] two-band frame, both divided");
    frameA();
    applyStimulus(0, NPIX, 1);
    drainAndCheck("frameA");

    $display("[TB] band 0 only");
    clearFrame();
    frame[6][4]  = 8;
    frame[7][10] = 8;
    applyStimulus(0, NPIX, 1);
    drainAndCheck("band0_only");

    $display("[TB] empty frame");
    clearFrame();
    applyStimulus(0, NPIX, 1);
    drainAndCheck("empty");

    $display("[TB] truncating division");
    clearFrame();
    frame[6][2]  = 3;
    frame[7][11] = 5;
    applyStimulus(0, NPIX, 1);
    drainAndCheck("trunc");

    $display("[TB] below minimum weight");
    clearFrame();
    frame[7][3] = 3;
    applyStimulus(0, NPIX, 1);
    drainAndCheck("min_weight");

    $display("[TB] frame A with input gaps");
    frameA();
    applyStimulus(50, NPIX, 1);
    drainAndCheck("gaps");

    $display("[TB] random frames back to back");
    for (int f = 0; f < 4; f++) begin
      randomFrame((f % 2 == 0) ? 30 : 8);
      applyStimulus((f == 3) ? 30 : 0, NPIX, 1);
    end
    drainAndCheck("random");

    $display("[TB] reset mid-frame");
    randomFrame(40);
    applyStimulus(0, 100, 0);
    pulseReset();
    frameA();
    applyStimulus(0, NPIX, 1);
    drainAndCheck("post_reset");

    $display("[TB] reset mid-division");
    randomFrame(40);
    frame[7][8] = 15;
    applyStimulus(0, NPIX, 0);
    idle(3);
    pulseReset();
    drainAndCheck("div_abort");

    $display("[TB] recovery after aborted division");
    clearFrame();
    frame[6][12] = 10;
    frame[4][1]  = 2;
    frame[5][2]  = 6;
    applyStimulus(20, NPIX, 1);
    drainAndCheck("recovery");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
